video_crop: RTL and testbench
=============================

# video_crop

Streaming region-of-interest cropper that sits directly downstream of the video pattern generator. It consumes its sop/eop/valid pixel stream and drives that generator's `ready` input. It forwards only the pixels inside a fixed rectangular window, regenerating sop/eop for the cropped frame. It also detects frame-framing errors and absorbs downstream back-pressure with a 2-entry skid buffer.

## Interface
- BITS, 8, pixel bit depth
- ROWS, 240, input frame rows
- COLS, 320, input frame columns
- X0, 0, first cropped column; X0+OUT_COLS <= COLS
- Y0, 0, first cropped row; Y0+OUT_ROWS <= ROWS
- OUT_COLS, 160, cropped width, >= 1
- OUT_ROWS, 120, cropped height, >= 1

Ports (name, direction, width, meaning):
- clk  in  1  clock
- srst  in  1  reset, synchronous, active-high
- in_data  in  BITS  upstream pixel
- in_sop / in_eop / in_valid  in  1  upstream framing and qualifier
- in_ready  out  1  to upstream `ready`; a beat transfers when in_valid && in_ready at a rising edge
- out_data  out  BITS  cropped pixel
- out_sop / out_eop / out_valid  out  1  cropped framing and qualifier
- out_ready  in  1  downstream accept; a transfer occurs on out_valid && out_ready
- err_short / err_long / err_sync  out  1  one-cycle error pulses

## Operation
- States are WAIT_SOP and ACTIVE. Column and row counters track the input position, clog2 width each.
- **WAIT_SOP:** beats without in_sop are accepted and discarded. A beat with in_sop counts as position (0,0) and moves the block to ACTIVE.
- **ACTIVE, position advance:** each accepted beat advances the column; at COLS-1 the column wraps to 0 and the row increments.
- **Window pass-through:** a beat with X0 <= col < X0+OUT_COLS and Y0 <= row < Y0+OUT_ROWS is pushed into the skid buffer. Beats outside the window are discarded.
- **Output framing:** out_sop = 1 on the pixel at (Y0,X0). out_eop = 1 on the pixel at (Y0+OUT_ROWS-1, X0+OUT_COLS-1).
- **Normal frame end:** a beat at (ROWS-1, COLS-1) carrying in_eop returns the block to WAIT_SOP.
- **err_short:** in_eop arrives before the last position. Pulse err_short and go to WAIT_SOP. No synthetic eop is generated.
- **err_long:** the last position arrives without in_eop. Pulse err_long and go to WAIT_SOP.
- **err_sync:** in_sop arrives in ACTIVE at any position other than (0,0). Pulse err_sync and treat the beat as (0,0) of a new frame; the state stays ACTIVE.
- **Precedence:** when in_sop and in_eop both arrive mid-frame, err_sync takes precedence.
- **Data path:** pixel data is passed unmodified.

## Timing
- **Reset values:** during srst, in_ready = 0, out_valid = out_sop = out_eop = 0, out_data = 0, all err_* = 0. The state is WAIT_SOP, the counters are 0 and the skid buffer is empty.
- in_ready = 1 in the first cycle after srst deasserts.
- **Latency:** an accepted in-window beat appears on the outputs on the next cycle if the skid buffer was empty.
- **in_ready:** registered, and equals "skid second entry empty".
- **Skid capacity:** one beat arriving in the same cycle that in_ready falls is held in the second entry, so no beat is lost.
- **Discarded beats:** they still require in_ready = 1; back-pressure stalls the input uniformly.
- **Output stability:** out_data/sop/eop stay stable while out_valid && !out_ready.
- **Error pulses:** each err_* pulse is registered, one cycle, and occurs in the cycle after the offending beat is accepted.
- **Reset mid-frame:** srst mid-frame flushes the skid buffer; any partial output frame is abandoned.

## Configuration
- Macro: VIDEO_CROP_STATS_EN.
- **With the macro defined:** adds outputs frame_count[15:0] and err_count[15:0].
  - frame_count increments on each out_eop transfer.
  - err_count increments on any err_* pulse.
  - Both counters saturate at 16'hFFFF and are cleared by srst.
- **Without the macro:** these ports and counters do not exist.

## Structure
- **Shared package video_pkg:** holds the state enum (WAIT_SOP, ACTIVE), a clog2-based position-width constant function, and the beat struct {data, sop, eop}.
- **Sub-module video_skid:** a 2-entry registered-ready skid buffer, parameterized by payload width. It is reusable by other video stages.

## Test plan
- **Basic crop:** ROWS=8, COLS=8, X0=2, Y0=3, OUT_COLS=4, OUT_ROWS=2, horizontal-gradient source, out_ready=1.
  - Expect 8 output beats, data 2,3,4,5,2,3,4,5.
  - out_sop on beat 1 only, out_eop on beat 8 only, one-cycle latency.
- **Back-pressure:** same stream, out_ready random at 50% for 3 frames.
  - The output sequence is identical to the basic case with no drops or duplicates.
  - in_ready falls within one cycle of the skid buffer filling.
- **Mid-frame start:** the source starts at position (4,0) with no sop.
  - All beats are discarded until the next sop; the first output beat has out_sop=1, data 2.
- **Short frame:** in_eop injected at position (5,0) of a 64-pixel frame.
  - err_short pulses once and no out_eop is emitted for that frame.
  - The next frame crops correctly.
- **Sync error:** in_sop injected at (2,5).
  - err_sync pulses; counting restarts from that beat, and the first window pixel comes 3*8+2 beats later.
- **Reset with full skid:** srst asserted with the skid buffer full and out_ready=0.
  - Next cycle: out_valid=0 and in_ready=0. After release: in_ready=1, and the first output is the next frame's sop pixel.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared state enum, beat struct and position-width helper for video stages
package video_pkg;
  localparam int BEAT_BITS = 8;
  typedef enum logic {WAIT_SOP, ACTIVE} state_t;
  typedef struct packed {
    logic [BEAT_BITS-1:0] data;
    logic                 sop;
    logic                 eop;
  } beat_t;
  function automatic int pos_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/video_skid.sv
// video_skid: 2-entry skid buffer with registered ready, generic payload width
module video_skid #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] s_data;
  logic s_valid, push, free, s_valid_n, o_valid_n;
  always_comb begin
    push = in_valid && in_ready;
    free = !out_valid || out_ready;
    s_valid_n = !free && (s_valid || push);
    o_valid_n = free ? (s_valid || push) : 1'b1;
  end
  always_ff @(posedge clk)
    if (srst) begin
      s_valid   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      s_data    <= '0;
      out_data  <= '0;
    end else begin
      s_valid   <= s_valid_n;
      out_valid <= o_valid_n;
      in_ready  <= !s_valid_n;
      if (free && (s_valid || push)) out_data <= s_valid ? s_data : in_data;
      if (!free && push) s_data <= in_data;
    end
endmodule

// File: rtl/video_crop.sv
// video_crop: fixed-window stream cropper with framing-error pulses and skid output.
// Defining VIDEO_CROP_STATS_EN adds saturating frame_count/err_count outputs.
module video_crop
  import video_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int ROWS     = 240,
  parameter int COLS     = 320,
  parameter int X0       = 0,
  parameter int Y0       = 0,
  parameter int OUT_COLS = 160,
  parameter int OUT_ROWS = 120
) (
  input  logic            clk,
  input  logic            srst,
  input  logic [BITS-1:0] in_data,
  input  logic            in_sop,
  input  logic            in_eop,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_sop,
  output logic            out_eop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err_short,
  output logic            err_long,
  output logic            err_sync
`ifdef VIDEO_CROP_STATS_EN
  ,
  output logic [15:0]     frame_count,
  output logic [15:0]     err_count
`endif
);
  localparam int CW = pos_w(COLS);
  localparam int RW = pos_w(ROWS);
  state_t state, state_n;
  logic [CW-1:0] col, col_n, cc;
  logic [RW-1:0] row, row_n, cr;
  logic accept, live, last, last_col, in_win, sync_e, short_e, long_e, push;
  beat_t in_beat, out_beat;
  always_comb begin
    accept   = in_valid && in_ready;
    live     = accept && (state == ACTIVE || in_sop);
    cc       = in_sop ? '0 : col;
    cr       = in_sop ? '0 : row;
    last_col = int'(cc) == COLS - 1;
    last     = last_col && int'(cr) == ROWS - 1;
    in_win   = int'(cc) >= X0 && int'(cc) < X0 + OUT_COLS && int'(cr) >= Y0 && int'(cr) < Y0 + OUT_ROWS;
    sync_e   = accept && state == ACTIVE && in_sop && (col != '0 || row != '0);
    short_e  = live && in_eop && !last && !sync_e;
    long_e   = live && last && !in_eop;
    push     = live && in_win;
    in_beat.data = BEAT_BITS'(in_data);
    in_beat.sop  = int'(cc) == X0 && int'(cr) == Y0;
    in_beat.eop  = int'(cc) == X0 + OUT_COLS - 1 && int'(cr) == Y0 + OUT_ROWS - 1;
    state_n = state;
    col_n   = col;
    row_n   = row;
    if (live && (last || short_e)) begin
      state_n = WAIT_SOP;
      col_n   = '0;
      row_n   = '0;
    end else if (live) begin
      state_n = ACTIVE;
      col_n   = last_col ? '0 : cc + 1'b1;
      row_n   = last_col ? cr + 1'b1 : cr;
    end
  end
  always_ff @(posedge clk)
    if (srst) begin
      state     <= WAIT_SOP;
      col       <= '0;
      row       <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      err_short <= short_e;
      err_long  <= long_e;
      err_sync  <= sync_e;
    end
  video_skid #(.W($bits(beat_t))) u_skid (
    .clk      (clk),
    .srst     (srst),
    .in_data  (in_beat),
    .in_valid (push),
    .in_ready (in_ready),
    .out_data (out_beat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  assign out_data = BITS'(out_beat.data);
  assign out_sop  = out_beat.sop;
  assign out_eop  = out_beat.eop;
`ifdef VIDEO_CROP_STATS_EN
  always_ff @(posedge clk)
    if (srst) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (out_valid && out_ready && out_eop && frame_count != '1) frame_count <= frame_count + 1'b1;
      if ((err_short || err_long || err_sync) && err_count != '1) err_count <= err_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_video_crop.sv
// tb_video_crop: directed checks of the 8x8 -> 4x2 crop at (2,3) on a column-gradient source
module tb_video_crop;
  logic clk = 0, srst = 1;
  logic [7:0] in_data = 0;
  logic in_sop = 0, in_eop = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_sop, out_eop, out_valid, err_short, err_long, err_sync;
  logic [7:0] out_data;
`ifdef VIDEO_CROP_STATS_EN
  logic [15:0] frame_count, err_count;
`endif
  int total = 0, bad = 0, rd_mode = 0;
  int n_short = 0, n_long = 0, n_sync = 0;
  logic [9:0] got[$], exp_q[$];
  logic pv = 0, pr = 0, prs = 1;
  logic [9:0] pb = 0;

  video_crop #(.BITS(8), .ROWS(8), .COLS(8), .X0(2), .Y0(3), .OUT_COLS(4), .OUT_ROWS(2)) dut (
    .clk(clk), .srst(srst), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready),
    .err_short(err_short), .err_long(err_long), .err_sync(err_sync)
`ifdef VIDEO_CROP_STATS_EN
    , .frame_count(frame_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rd_mode == 0 ? 1'b1 : rd_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // output monitor: records transfers, counts error pulses, checks hold-while-stalled
  always @(negedge clk) begin
    if (!srst && !prs && pv && !pr) begin
      total++;
      if (out_valid !== 1'b1 || {out_data, out_sop, out_eop} !== pb) begin
        bad++;
        $display("FAIL stable: got valid=%b beat=%h, required valid=1 beat=%h", out_valid, {out_data, out_sop, out_eop}, pb);
      end
    end
    if (!srst && out_valid && out_ready) got.push_back({out_data, out_sop, out_eop});
    if (err_short) n_short++;
    if (err_long) n_long++;
    if (err_sync) n_sync++;
    pv = out_valid;
    pr = out_ready;
    pb = {out_data, out_sop, out_eop};
    prs = srst;
  end

  function automatic logic in_window(input int p);
    return p / 8 >= 3 && p / 8 <= 4 && p % 8 >= 2 && p % 8 <= 5;
  endfunction

  function automatic void add_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(2 + i % 4), i == 0, i == 7});
  endfunction

  task automatic clear();
    got.delete();
    exp_q.delete();
    n_short = 0;
    n_long = 0;
    n_sync = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, input logic w);
    logic acc, full;
    int n = 0;
    in_data = d;
    in_sop = s;
    in_eop = e;
    in_valid = 1;
    do begin
      @(negedge clk);
      acc = in_ready;
      full = out_valid && !out_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    in_valid = 0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL in_ready timeout: waited %0d cycles, required in_ready=1", n);
    end else if (w && full) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_fall: in_ready=%b after skid filled, required 0", in_ready);
      end
    end
  endtask

  task automatic send_range(input int from, input int to, input int sop_at, input int eop_at);
    for (int p = from; p <= to; p++) send_beat(8'(p % 8), p == 0 || p == sop_at, p == eop_at, in_window(p));
  endtask

  task automatic drain();
    int q = 0, n = 0;
    while (q < 4 && n < 300) begin
      @(negedge clk);
      q = out_valid ? 0 : q + 1;
      n++;
    end
    @(posedge clk);
    #1;
    if (q < 4) begin
      total++;
      bad++;
      $display("FAIL drain timeout: out_valid still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_sop, out_eop, out_data, err_short, err_long, err_sync} !== 15'd0) begin
      bad++;
      $display("FAIL reset outputs: got %b, required all zero", {in_ready, out_valid, out_sop, out_eop, out_data, err_short, err_long, err_sync});
    end
    @(posedge clk);
    #1;
    srst = 0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset release: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    clear();
    add_frame();
    send_range(0, 26, -1, 63);
    total++;
    if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 8'd2) begin
      bad++;
      $display("FAIL basic latency: valid=%b sop=%b data=%0d, required 1 1 2", out_valid, out_sop, out_data);
    end
    send_range(27, 63, -1, 63);
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL basic count: got %0d beats, required %0d", got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic beat %0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (n_short != 0 || n_long != 0 || n_sync != 0) begin
      bad++;
      $display("FAIL basic errors: short=%0d long=%0d sync=%0d, required 0 0 0", n_short, n_long, n_sync);
    end
  endtask

  task automatic test_back_pressure();
    clear();
    rd_mode = 1;
    for (int f = 0; f < 3; f++) begin
      add_frame();
      send_range(0, 63, -1, 63);
    end
    rd_mode = 0;
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL backpressure count: got %0d beats, required %0d", got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL backpressure beat %0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_start();
    clear();
    add_frame();
    send_range(32, 63, -1, 63);
    send_range(0, 63, -1, 63);
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL midstart count: got %0d beats, required %0d", got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL midstart beat %0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (n_short != 0 || n_long != 0 || n_sync != 0) begin
      bad++;
      $display("FAIL midstart errors: short=%0d long=%0d sync=%0d, required 0 0 0", n_short, n_long, n_sync);
    end
  endtask

  task automatic test_short();
    clear();
    add_frame();
    send_range(0, 63, -1, 40);
    exp_q.push_back({8'd2, 2'b10});
    exp_q.push_back({8'd3, 2'b00});
    exp_q.push_back({8'd4, 2'b00});
    exp_q.push_back({8'd5, 2'b00});
    exp_q.push_back({8'd2, 2'b00});
    exp_q.push_back({8'd3, 2'b00});
    send_range(0, 63, -1, 35);
    add_frame();
    send_range(0, 63, -1, 63);
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL short count: got %0d beats, required %0d", got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL short beat %0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (n_short != 2 || n_long != 0 || n_sync != 0) begin
      bad++;
      $display("FAIL short errors: short=%0d long=%0d sync=%0d, required 2 0 0", n_short, n_long, n_sync);
    end
  endtask

  task automatic test_long();
    clear();
    add_frame();
    send_range(0, 63, -1, -1);
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL long count: got %0d beats, required %0d", got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL long beat %0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (n_short != 0 || n_long != 1 || n_sync != 0) begin
      bad++;
      $display("FAIL long errors: short=%0d long=%0d sync=%0d, required 0 1 0", n_short, n_long, n_sync);
    end
  endtask

  task automatic test_sync();
    clear();
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(i % 4 == 0 ? 7 : i % 4 - 1), i == 0, i == 7});
    send_range(0, 63, 21, 63);
    add_frame();
    send_range(0, 63, -1, 63);
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL sync count: got %0d beats, required %0d", got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL sync beat %0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (n_short != 1 || n_long != 0 || n_sync != 1) begin
      bad++;
      $display("FAIL sync errors: short=%0d long=%0d sync=%0d, required 1 0 1", n_short, n_long, n_sync);
    end
  endtask

  task automatic test_precedence();
    clear();
    add_frame();
    send_range(0, 21, 21, 21);
    send_range(1, 63, -1, 63);
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL precedence count: got %0d beats, required %0d", got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL precedence beat %0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (n_short != 0 || n_long != 0 || n_sync != 1) begin
      bad++;
      $display("FAIL precedence errors: short=%0d long=%0d sync=%0d, required 0 0 1", n_short, n_long, n_sync);
    end
  endtask

  task automatic test_reset_full();
    rd_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_range(0, 27, -1, -1);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL skid full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
    end
    srst = 1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset flush: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    srst = 0;
    rd_mode = 0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_full release: in_ready=%b, required 1", in_ready);
    end
    clear();
    add_frame();
    send_range(0, 63, -1, 63);
    drain();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL reset_full count: got %0d beats, required %0d", got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL reset_full beat %0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_mid_start();
    test_short();
    test_long();
    test_sync();
    test_precedence();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
